// File: rtl/main_mem_pkg.sv
// Shared types and constants for the main memory responder: FSM states, default
// geometry, derived widths and reset values.
package main_mem_pkg;

    localparam int unsigned DefDataW      = 32;
    localparam int unsigned DefDepthWords = 1024;
    localparam int unsigned DefBlockWords = 4;
    localparam int unsigned DefLatency    = 3;

    localparam int unsigned DefIdxW = $clog2(DefDepthWords);
    localparam int unsigned DefOffW = $clog2(DefBlockWords);
    localparam int unsigned DefCntW = $clog2(DefLatency + 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StBurst,
        StDoneW
    } state_e;

    localparam state_e RstState = StIdle;
    localparam logic   RstBusy  = 1'b0;
    localparam logic   RstValid = 1'b0;
    localparam logic   RstDone  = 1'b0;

    // Width of a down-counter that must hold the value n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/main_mem_array.sv
// Word-addressed storage: synchronous write, asynchronous read. Word i reads as i
// until it is first written; the array is never cleared by reset.
module main_mem_array
    import main_mem_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned DEPTH_WORDS = DefDepthWords,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0]      mem [DEPTH_WORDS];
    // Power-up contents come from the index itself; a per-word flag selects stored data.
    logic [DEPTH_WORDS-1:0] written = '0;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr]     <= wdata;
            written[waddr] <= 1'b1;
        end
    end

    assign rdata = written[raddr] ? mem[raddr] : DATA_W'(raddr);

endmodule

// File: rtl/main_memory_responder.sv
// Main memory responder behind the data cache: fixed-latency block refill or word write.
// Define MAIN_MEM_CRITICAL_WORD_FIRST_EN to start refills at the requested word and wrap.
module main_memory_responder
    import main_mem_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned DEPTH_WORDS = DefDepthWords,
    parameter int unsigned BLOCK_WORDS = DefBlockWords,
    parameter int unsigned LATENCY     = DefLatency
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           memReq,
    input  logic                           memWe,
    input  logic [31:0]                    memAddr,
    input  logic [DATA_W-1:0]              memWData,
    output logic                           memBusy,
    output logic                           memRValid,
    output logic [DATA_W-1:0]              memRData,
    output logic [$clog2(BLOCK_WORDS)-1:0] memRIndex,
    output logic                           memDone
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
    localparam int unsigned CNT_W = cnt_width(LATENCY);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [OFF_W-1:0]    beat_q, beat_d;
    logic [OFF_W-1:0]    off_q, off_d;

    logic [IDX_W-1:0]    req_idx;
    logic [OFF_W-1:0]    start_off;
    logic [IDX_W-1:0]    rd_idx;
    logic [DATA_W-1:0]   arr_rdata;
    logic                arr_we;
    logic                last_beat;
    logic                unused_addr;

    assign req_idx     = memAddr[IDX_W+1:2];
    assign unused_addr = ^{memAddr[31:IDX_W+2], memAddr[1:0]};

`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
    assign start_off = req_idx[OFF_W-1:0];
`else
    assign start_off = '0;
`endif

    assign last_beat = (beat_q == OFF_W'(BLOCK_WORDS - 1));
    assign rd_idx    = {idx_q[IDX_W-1:OFF_W], off_q};
    // The commit edge is the last WAIT edge; a coincident reset suppresses it.
    assign arr_we    = (state_q == StWait) && (cnt_q == CNT_W'(1)) && we_q && !rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        beat_d  = beat_q;
        off_d   = off_q;
        unique case (state_q)
            StIdle: begin
                if (memReq) begin
                    we_d    = memWe;
                    idx_d   = req_idx;
                    wdata_d = memWData;
                    cnt_d   = CNT_W'(LATENCY);
                    beat_d  = '0;
                    off_d   = start_off;
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = we_q ? StDoneW : StBurst;
                end
            end
            StBurst: begin
                beat_d = beat_q + OFF_W'(1);
                off_d  = off_q + OFF_W'(1);
                if (last_beat) begin
                    state_d = StIdle;
                end
            end
            StDoneW: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RstState;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            beat_q  <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            beat_q  <= beat_d;
            off_q   <= off_d;
        end
    end

    main_mem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (rd_idx),
        .rdata (arr_rdata)
    );

    assign memBusy   = (state_q != StIdle);
    assign memRValid = (state_q == StBurst);
    assign memRData  = memRValid ? arr_rdata : '0;
    assign memRIndex = memRValid ? off_q : '0;
    assign memDone   = ((state_q == StBurst) && last_beat) || (state_q == StDoneW);

endmodule
